// File: rtl/parking_pkg.sv
// Shared types and constants for the parking occupancy monitor.
//   gate_state_t : per-gate passage-tracking state
//   CODE_*       : sensor code {outer, inner}
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6
  } gate_state_t;

  localparam logic [1:0] CODE_CLR  = 2'b00;
  localparam logic [1:0] CODE_IN   = 2'b01;
  localparam logic [1:0] CODE_OUT  = 2'b10;
  localparam logic [1:0] CODE_BOTH = 2'b11;

endpackage

// File: rtl/gate_fsm.sv
// Single-gate passage recogniser. Emits one-cycle enter/exit pulses for
// complete, in-order passages only.
//   clk, reset     : clock, synchronous active-high reset
//   outer, inner   : beam-blocked inputs (street side, lot side)
//   enter, exit    : registered one-cycle event pulses
//   enter_c, exit_c: combinational event about to be registered this edge,
//                    used by the top so count updates together with the pulse
module gate_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic outer,
  input  logic inner,
  output logic enter,
  output logic exit,
  output logic enter_c,
  output logic exit_c
);

  gate_state_t state_q;
  logic [1:0]  code;

  assign code    = {outer, inner};
  assign enter_c = (state_q == E3) && (code == CODE_CLR);
  assign exit_c  = (state_q == X3) && (code == CODE_CLR);

  // State register and event pulses; exit states mirror entry with beams swapped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      enter   <= 1'b0;
      exit    <= 1'b0;
    end else begin
      enter <= enter_c;
      exit  <= exit_c;
      case (state_q)
        IDLE: begin
          // Both beams blocked from idle is ambiguous, so it is ignored.
          if (code == CODE_OUT)     state_q <= E1;
          else if (code == CODE_IN) state_q <= X1;
        end
        E1: begin
          if (code == CODE_BOTH)     state_q <= E2;
          else if (code != CODE_OUT) state_q <= IDLE;
        end
        E2: begin
          if (code == CODE_IN)       state_q <= E3;
          else if (code == CODE_OUT) state_q <= E1;
          else if (code == CODE_CLR) state_q <= IDLE;
        end
        E3: begin
          if (code == CODE_BOTH)    state_q <= E2;
          else if (code != CODE_IN) state_q <= IDLE;
        end
        X1: begin
          if (code == CODE_BOTH)    state_q <= X2;
          else if (code != CODE_IN) state_q <= IDLE;
        end
        X2: begin
          if (code == CODE_OUT)      state_q <= X3;
          else if (code == CODE_IN)  state_q <= X1;
          else if (code == CODE_CLR) state_q <= IDLE;
        end
        X3: begin
          if (code == CODE_BOTH)     state_q <= X2;
          else if (code != CODE_OUT) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_occupancy_monitor.sv
// Lot occupancy monitor: one gate_fsm per gate, events aggregated into a
// saturating occupancy count with full/empty flags and a sticky error.
//   clk, reset    : clock, synchronous active-high reset
//   outer, inner  : per-gate beam inputs
//   enter, exit   : per-gate one-cycle event pulses
//   count         : current occupancy
//   full, empty   : count == CAPACITY, count == 0
//   err           : sticky saturation flag, cleared only by reset
module parking_occupancy_monitor
  import parking_pkg::*;
#(
  parameter int unsigned NUM_GATES = 2,
  parameter int unsigned CAPACITY  = 15,
  parameter int unsigned COUNT_W   = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] outer,
  input  logic [NUM_GATES-1:0] inner,
  output logic [NUM_GATES-1:0] enter,
  output logic [NUM_GATES-1:0] exit,
  output logic [COUNT_W-1:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  localparam int unsigned NET_W = COUNT_W + $clog2(NUM_GATES) + 2;
  localparam logic signed [NET_W-1:0] CAP_S = NET_W'(CAPACITY);

  logic [NUM_GATES-1:0]    enter_c;
  logic [NUM_GATES-1:0]    exit_c;
  logic signed [NET_W-1:0] ent_pc_c;
  logic signed [NET_W-1:0] ext_pc_c;
  logic signed [NET_W-1:0] sum_c;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic                    full_q, empty_q, err_q, err_d;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    gate_fsm u_gate (
      .clk     (clk),
      .reset   (reset),
      .outer   (outer[g]),
      .inner   (inner[g]),
      .enter   (enter[g]),
      .exit    (exit[g]),
      .enter_c (enter_c[g]),
      .exit_c  (exit_c[g])
    );
  end

  // Net entries and exits first, then clamp the result to [0, CAPACITY].
  always_comb begin
    ent_pc_c = '0;
    ext_pc_c = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      ent_pc_c = ent_pc_c + NET_W'(enter_c[g]);
      ext_pc_c = ext_pc_c + NET_W'(exit_c[g]);
    end
    sum_c   = $signed(NET_W'(count_q)) + ent_pc_c - ext_pc_c;
    count_d = COUNT_W'(sum_c);
    err_d   = err_q;
    if (sum_c[NET_W-1]) begin
      count_d = '0;
      err_d   = 1'b1;
    end else if (sum_c > CAP_S) begin
      count_d = COUNT_W'(CAPACITY);
      err_d   = 1'b1;
    end
  end

  // Count and flags are registered together so they always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == COUNT_W'(CAPACITY));
      empty_q <= (count_d == '0);
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

endmodule

// File: tb/tb_parking_occupancy_monitor.sv
// Self-checking bench: directed scenarios plus randomized per-gate sensor
// streams, compared every cycle against a position-on-a-line passage model.
module tb_parking_occupancy_monitor;

  localparam int unsigned NG  = 2;
  localparam int unsigned CAP = 6;
  localparam int unsigned CW  = $clog2(CAP + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [NG-1:0] outer, inner, enter_w, exit_w;
  logic [CW-1:0] count_w;
  logic          full_w, empty_w, err_w;

  parking_occupancy_monitor #(
    .NUM_GATES (NG),
    .CAPACITY  (CAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .outer (outer),
    .inner (inner),
    .enter (enter_w),
    .exit  (exit_w),
    .count (count_w),
    .full  (full_w),
    .empty (empty_w),
    .err   (err_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 none, 1 entering, 2 exiting; depth = how far along the
  // three-step path (1..3) the car is, in the direction of travel.
  int      m_mode  [NG];
  int      m_depth [NG];
  int      m_count;
  bit      m_err;
  bit [NG-1:0] m_enter, m_exit;

  logic [1:0] code [NG];
  logic [1:0] sq0 [$];
  logic [1:0] sq1 [$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Position along the street-to-lot line: outer=1, both=2, inner=3.
  function automatic int line_pos(input logic [1:0] c);
    case (c)
      2'b10:   return 1;
      2'b11:   return 2;
      2'b01:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit rst);
    int net;
    int p;
    int s;
    m_enter = '0;
    m_exit  = '0;
    if (rst) begin
      for (int g = 0; g < NG; g++) m_mode[g] = 0;
      m_count = 0;
      m_err   = 0;
      return;
    end
    net = 0;
    for (int g = 0; g < NG; g++) begin
      p = line_pos(code[g]);
      if (m_mode[g] == 2 && p != 0) p = 4 - p;
      if (m_mode[g] == 0) begin
        if (code[g] == 2'b10)      begin m_mode[g] = 1; m_depth[g] = 1; end
        else if (code[g] == 2'b01) begin m_mode[g] = 2; m_depth[g] = 1; end
      end else if (p == 0) begin
        if (m_depth[g] == 3) begin
          if (m_mode[g] == 1) begin m_enter[g] = 1'b1; net++; end
          else                begin m_exit[g]  = 1'b1; net--; end
        end
        m_mode[g] = 0;
      end else if (p - m_depth[g] <= 1 && m_depth[g] - p <= 1) begin
        m_depth[g] = p;
      end else begin
        m_mode[g] = 0;
      end
    end
    s = m_count + net;
    if (s > int'(CAP))  begin m_count = CAP; m_err = 1; end
    else if (s < 0)     begin m_count = 0;   m_err = 1; end
    else                m_count = s;
  endtask

  task automatic cycle(input bit rst);
    reset = rst;
    for (int g = 0; g < NG; g++) begin
      outer[g] = code[g][1];
      inner[g] = code[g][0];
    end
    model_step(rst);
    @(posedge clk);
    #1;
    check("enter", 32'(enter_w), 32'(m_enter));
    check("exit",  32'(exit_w),  32'(m_exit));
    check("count", 32'(count_w), m_count);
    check("full",  32'(full_w),  32'(m_count == int'(CAP)));
    check("empty", 32'(empty_w), 32'(m_count == 0));
    check("err",   32'(err_w),   32'(m_err));
  endtask

  task automatic push(input int g, input logic [1:0] c);
    if (g == 0) sq0.push_back(c);
    else        sq1.push_back(c);
  endtask

  // Clean passage with each code held 1..maxd cycles.
  task automatic pass(input int g, input bit is_exit, input int maxd);
    logic [1:0] first, last;
    first = is_exit ? 2'b01 : 2'b10;
    last  = is_exit ? 2'b10 : 2'b01;
    repeat ($urandom_range(1, maxd)) push(g, first);
    repeat ($urandom_range(1, maxd)) push(g, 2'b11);
    repeat ($urandom_range(1, maxd)) push(g, last);
    push(g, 2'b00);
  endtask

  task automatic rock(input int g, input bit is_exit);
    logic [1:0] first, last;
    first = is_exit ? 2'b01 : 2'b10;
    last  = is_exit ? 2'b10 : 2'b01;
    push(g, first); push(g, 2'b11); push(g, last);
    push(g, 2'b11); push(g, first); push(g, 2'b11);
    push(g, last);  push(g, 2'b00);
  endtask

  task automatic drain();
    while (sq0.size() != 0 || sq1.size() != 0) begin
      code[0] = (sq0.size() != 0) ? sq0.pop_front() : 2'b00;
      code[1] = (sq1.size() != 0) ? sq1.pop_front() : 2'b00;
      cycle(1'b0);
    end
  endtask

  task automatic refill(input int g);
    case ($urandom_range(0, 6))
      0, 1:    pass(g, 1'b0, 3);
      2, 3:    pass(g, 1'b1, 3);
      4:       rock(g, 1'($urandom_range(0, 1)));
      5:       repeat ($urandom_range(1, 5)) push(g, 2'($urandom_range(0, 3)));
      default: repeat ($urandom_range(1, 3)) push(g, 2'b00);
    endcase
  endtask

  initial begin
    code[0] = 2'b00;
    code[1] = 2'b00;
    reset = 1'b1;
    outer = '0;
    inner = '0;

    // Reset state
    cycle(1'b1);
    cycle(1'b1);

    // Single clean entry on gate 0
    pass(0, 1'b0, 1);
    drain();
    check("t1_count", 32'(count_w), 1);

    // Aborted entry, then rocking entry
    push(0, 2'b10); push(0, 2'b11); push(0, 2'b10); push(0, 2'b00);
    drain();
    check("t2_abort_count", 32'(count_w), 1);
    rock(0, 1'b0);
    drain();
    check("t2_rock_count", 32'(count_w), 2);

    // Overfill: six more entries saturate at CAP
    for (int i = 0; i < 3; i++) begin
      pass(0, 1'b0, 2);
      pass(1, 1'b0, 2);
    end
    drain();
    check("t3_count", 32'(count_w), CAP);
    check("t3_full",  32'(full_w), 1);
    check("t3_err",   32'(err_w), 1);

    // Exit from empty lot underflows
    code[0] = 2'b00; code[1] = 2'b00;
    cycle(1'b1);
    pass(1, 1'b1, 1);
    drain();
    check("t4_count", 32'(count_w), 0);
    check("t4_err",   32'(err_w), 1);

    // Simultaneous entry on gate 0 and exit on gate 1 at count 2
    cycle(1'b1);
    pass(0, 1'b0, 1);
    pass(1, 1'b0, 1);
    drain();
    pass(0, 1'b0, 1);
    pass(1, 1'b1, 1);
    drain();
    check("t5_count", 32'(count_w), 2);
    check("t5_err",   32'(err_w), 0);

    // Reset mid-entry discards the partial passage
    cycle(1'b1);
    for (int i = 0; i < 5; i++) pass(i % 2, 1'b0, 2);
    drain();
    check("t6_count5", 32'(count_w), 5);
    push(0, 2'b10); push(0, 2'b11); push(0, 2'b01);
    drain();
    code[0] = 2'b01; code[1] = 2'b00;
    cycle(1'b1);
    check("t6_count0", 32'(count_w), 0);
    code[0] = 2'b00;
    cycle(1'b0);
    check("t6_no_enter", 32'(enter_w), 0);
    cycle(1'b0);

    // Randomized streams with occasional resets
    for (int n = 0; n < 4000; n++) begin
      if (sq0.size() == 0) refill(0);
      if (sq1.size() == 0) refill(1);
      code[0] = sq0.pop_front();
      code[1] = sq1.pop_front();
      cycle($urandom_range(0, 399) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_monitor.md
# parking_occupancy_monitor

- Tracks cars through `NUM_GATES` independent gates, each with an outer (street-side) and inner (lot-side) beam sensor.
- Recognises only complete, in-order passages: enter is outer → both → inner → clear; exit is inner → both → outer → clear. Aborted, reversed or skipped sequences produce no event.
- Aggregates per-gate events into a saturating lot occupancy count with full/empty status and a sticky error flag.
- Sits between the sensor inputs and the lot display/gate-control logic.

## Interface

Parameters:
- `NUM_GATES`, default 2: number of gates, ≥1.
- `CAPACITY`, default 15: maximum occupancy, ≥1.
- `COUNT_W`, default `$clog2(CAPACITY+1)`: occupancy width (derived).

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `outer` in `NUM_GATES`: outer beam blocked, one bit per gate. Synchronous to `clk`; synchronisation is the caller's responsibility.
- `inner` in `NUM_GATES`: inner beam blocked, one bit per gate.
- `enter` out `NUM_GATES`: one-cycle pulse per completed entry.
- `exit` out `NUM_GATES`: one-cycle pulse per completed exit.
- `count` out `COUNT_W`: current occupancy.
- `full` out 1: `count == CAPACITY`.
- `empty` out 1: `count == 0`.
- `err` out 1: sticky; set on any saturation event.

## Operation

- **Per-gate FSM.** States IDLE, E1, E2, E3, X1, X2, X3. Sensor code `{outer,inner}`: 10 = outer only, 11 = both, 01 = inner only, 00 = clear.
  - IDLE: 10→E1; 01→X1; 00/11→IDLE. Both beams blocked from idle is ambiguous and ignored.
  - E1: 10 stay; 11→E2; 00→IDLE (abort); 01→IDLE (skip, invalid).
  - E2: 11 stay; 01→E3; 10→E1 (backing out); 00→IDLE.
  - E3: 01 stay; 11→E2; 10→IDLE; 00→IDLE and assert `enter`.
  - X1, X2, X3 mirror E1, E2, E3 with outer and inner swapped. X3 on 00→IDLE asserts `exit`.
- **Events.**
  - `enter[g]` and `exit[g]` are registered. Each is high for exactly one cycle, the cycle after the edge that samples the completing 00.
  - A gate never asserts both `enter[g]` and `exit[g]` in the same cycle.
- **Count arithmetic.**
  - `net = popcount(enter_next) − popcount(exit_next)`, computed signed at width `COUNT_W+$clog2(NUM_GATES)+2`.
  - `count + net > CAPACITY`: count saturates at CAPACITY and `err` is set.
  - `count + net < 0`: count saturates at 0 and `err` is set.
  - Simultaneous entries and exits on different gates net out before the bound checks. Example: count = CAPACITY with 1 enter + 1 exit gives count unchanged and no err.
  - Event pulses are emitted regardless of saturation.
- **Flags.** `full` and `empty` decode the `count` register only (glitch-free). `err` clears only on `reset`.

## Timing

- **Reset values:** all FSMs IDLE; `enter = exit = 0`; `count = 0`; `empty = 1`; `full = 0`; `err = 0`.
- **Reset priority:** `reset` overrides everything on the same edge. A gate mid-sequence at reset returns to IDLE and the partial passage is discarded.
- **Event latency:** the edge sampling the final 00 updates state, event register and `count` together. `count`, `full` and `empty` reflect the event in the same cycle the pulse is high.
- **Minimum passage:** a clean entry takes 4 sampled cycles (10, 11, 01, 00). Dwell in any state is unbounded; there are no timeouts.
- **Independence:** gates are fully independent, and all gates may complete in the same cycle.

## Structure

- **Package `parking_pkg`:**
  - `gate_state_t` enum (IDLE, E1, E2, E3, X1, X2, X3).
  - Sensor-code localparams `CODE_CLR`, `CODE_OUT`, `CODE_BOTH`, `CODE_IN`.
- **Sub-module `gate_fsm`:** one per gate via generate. Ports `clk`, `reset`, `outer`, `inner`, `enter`, `exit`. Contains the state register and the registered pulses.
- **Top level:** popcount, signed net/saturation logic, count register, flags and `err`.

## Test plan

1. Entry on gate 0, codes 10, 11, 01, 00 from reset → `enter[0]` high one cycle; `count` 0→1 in that cycle; `empty` 1→0.
2. Aborted entry, codes 10, 11, 10, 00 → no pulse; `count` unchanged. Then 10, 11, 01, 11, 01, 00 (rocking) → exactly one `enter`.
3. `CAPACITY=3`: four full entries → `count` reaches 3 with `full=1`; the 4th entry still pulses `enter`; `count` stays 3; `err` goes 1 and stays 1.
4. With count = 0, one exit (01, 11, 10, 00) → `exit` pulses; `count` stays 0; `err=1`.
5. `NUM_GATES=2`, count = 2: gate 0 entry and gate 1 exit complete on the same edge → both pulses high; `count` stays 2; `err=0`.
6. Assert `reset` while gate 0 is in E3 with count = 5 → next cycle count = 0 and FSM IDLE. A subsequent 00 produces no `enter`.
